fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Sequencer directly downstream of fetchbuffer: generates the fetch PC, drives fetchbuffer_in,
//  consumes mem_rdata/mem_ready, sizes each instruction (RVC 16-bit vs 32-bit) and queues
//  {pc,instr,comp} in a small FIFO for decode. Handles redirects (branch/trap) and fence.i.
// PARAMETERS
//  RESET_PC   32'h0  PC fetched after reset
//  QDEPTH     2      decode queue entries (power of 2, >=2)
// PORTS
//  clk              in   1            clock
//  rst              in   1            synchronous reset, active-high
//  redirect_valid   in   1            load new PC this cycle (flush)
//  redirect_addr    in   32           new PC; bit 0 ignored (forced 0)
//  redirect_mode    in   2            privilege mode for new stream
//  fence_valid      in   1            fence.i: invalidate fetchbuffer
//  dec_ready        in   1            decode accepts head entry
//  dec_valid        out  1            queue head valid
//  dec_pc           out  32           head PC
//  dec_instr        out  32           head instruction (upper 16 bits 0 if compressed)
//  dec_comp         out  1            head is 16-bit
//  fetchbuffer_in   out  mem_in_type  request to fetchbuffer
//  fetchbuffer_out  in   mem_out_type response from fetchbuffer
// BEHAVIOUR
//  - Reset: pc=RESET_PC, mode=m_mode, queue empty, dec_valid=0, dec_pc/instr/comp=0, state=SYNC.
//  - Request fields: mem_instr=1, mem_wdata=0, mem_wstrb=0, mem_addr=pc, mem_mode=mode.
//  - Response is same-cycle: mem_ready sampled in the cycle mem_valid=1 with that mem_addr.
//  - States: SYNC -> RUN; RUN -> SYNC on redirect; RUN/SYNC -> FENCE on fence_valid; FENCE -> RUN.
//    SYNC: mem_valid=1, mem_spec=1 (realigns fetchbuffer addr/mode); ready honoured as in RUN.
//    FENCE: one request with mem_fence=1, mem_spec=1, addr=pc; response discarded; next RUN.
//    RUN: mem_valid=1 iff queue count<QDEPTH; mem_spec=0, mem_fence=0.
//  - Accept (mem_valid & mem_ready & no redirect/fence this cycle): push {pc, rdata, comp},
//    comp=(rdata[1:0]!=2'b11); pc<=pc+2 if comp else pc+4 (32-bit wrap, no flag).
//  - No accept: pc held, same address re-requested next cycle (fetchbuffer miss/fence refill).
//  - Queue: dec_valid=count!=0; pop on dec_valid&dec_ready; push+pop same cycle keeps count.
//    Latency mem_ready -> dec_valid = 1 cycle (no bypass). Full: mem_valid=0 until a pop.
//  - redirect_valid (any state): queue flushed next cycle, current response dropped,
//    pc<={redirect_addr[31:1],1'b0}, mode<=redirect_mode, state<=SYNC; same-cycle pop ignored.
//  - fence_valid: queue flushed, current response dropped, state<=FENCE, pc unchanged
//    (caller redirects to fence.i+4 with redirect_valid in the same cycle).
//  - redirect & fence same cycle: pc/mode from redirect, state<=FENCE (fence request carries spec).
//  - rst mid-operation overrides all: returns to reset values next edge, in-flight data lost.
// TESTING
//  1 Reset, fetchbuffer always ready with 32-bit instrs -> first req spec=1 addr=0; dec_pc 0,4,8...
//    one per cycle, dec_valid rises 1 cycle after first mem_ready.
//  2 Mixed stream: rdata 0x00004501 at 0, 0x00A00093 at 2 -> dec_comp=1 pc=0, then comp=0 pc=2,
//    next request addr=6.
//  3 dec_ready=0 for 5 cycles -> after 2 accepts mem_valid=0, pc frozen; dec_ready=1 -> no loss/dup.
//  4 redirect_valid with addr 0x0000_1235, mode 2'b00, queue full -> queue empty next cycle,
//    next req addr=0x1234 spec=1 mode=0; no stale pc reaches decode.
//  5 fence_valid+redirect 0x100 -> one req mem_fence=1 addr=0x100, then mem_ready=0 for 16 cycles
//    -> addr 0x100 re-requested each cycle, dec_valid=0; first accept yields dec_pc=0x100.
//  6 rst asserted with 2 queued entries and pending miss -> next cycle dec_valid=0, req spec=1 addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch sequencer between fetchbuffer and decode
//
// Purpose: generates the fetch PC, issues requests to the fetchbuffer, sizes each
// returned instruction (16-bit compressed vs 32-bit) and queues {pc, instr, comp}
// for decode. Handles redirects (branch/trap) and fence.i invalidation.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   redirect_valid    load redirect_addr/redirect_mode and flush
//   redirect_addr     new PC (bit 0 forced to 0)
//   redirect_mode     privilege mode of the new stream
//   fence_valid       fence.i: issue one fence request to the fetchbuffer
//   dec_ready         decode consumes the queue head
//   dec_valid/pc/instr/comp   queue head towards decode (zero when empty)
//   fetchbuffer_in    request bundle to fetchbuffer
//   fetchbuffer_out   same-cycle response from fetchbuffer

package fetch_pkg;

  localparam logic [1:0] M_MODE = 2'b11;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_spec;
    logic        mem_fence;
    logic [1:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic [1:0]  redirect_mode,
  input  logic        fence_valid,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr,
  output logic        dec_comp,
  output mem_in_type  fetchbuffer_in,
  input  mem_out_type fetchbuffer_out
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FENCE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [1:0]     mode_q, mode_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  rd_ptr_q, wr_ptr_q;

  logic [31:0]    q_pc_q    [QDEPTH];
  logic [31:0]    q_instr_q [QDEPTH];
  logic           q_comp_q  [QDEPTH];

  logic           full;
  logic           flush;
  logic           push;
  logic           pop;
  logic           comp;
  logic [31:0]    push_instr;

  always_comb begin
    full  = (count_q == CW'(QDEPTH));
    flush = redirect_valid | fence_valid;
    pop   = (count_q != '0) & dec_ready;

    comp       = (fetchbuffer_out.mem_rdata[1:0] != 2'b11);
    push_instr = comp ? {16'h0, fetchbuffer_out.mem_rdata[15:0]}
                      : fetchbuffer_out.mem_rdata;

    fetchbuffer_in           = '0;
    fetchbuffer_in.mem_instr = 1'b1;
    fetchbuffer_in.mem_mode  = mode_q;
    fetchbuffer_in.mem_addr  = pc_q;

    state_d = state_q;
    case (state_q)
      ST_SYNC: begin
        // Speculative request realigns the fetchbuffer's address/mode tracking.
        fetchbuffer_in.mem_valid = 1'b1;
        fetchbuffer_in.mem_spec  = 1'b1;
        state_d                  = ST_RUN;
      end
      ST_FENCE: begin
        fetchbuffer_in.mem_valid = 1'b1;
        fetchbuffer_in.mem_spec  = 1'b1;
        fetchbuffer_in.mem_fence = 1'b1;
        state_d                  = ST_RUN;
      end
      default: begin
        fetchbuffer_in.mem_valid = ~full;
      end
    endcase

    // The fence request's response is never an instruction, and the full
    // guard keeps a SYNC request from overrunning the queue.
    push = fetchbuffer_in.mem_valid & fetchbuffer_out.mem_ready &
           ~flush & ~full & (state_q != ST_FENCE);

    pc_d   = pc_q;
    mode_d = mode_q;
    if (push) begin
      pc_d = pc_q + (comp ? 32'd2 : 32'd4);
    end
    if (redirect_valid) begin
      pc_d    = redirect_addr & 32'hFFFF_FFFE;
      mode_d  = redirect_mode;
      state_d = ST_SYNC;
    end
    // Fence wins the state; the PC still comes from a same-cycle redirect.
    if (fence_valid) begin
      state_d = ST_FENCE;
    end

    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
    end

    dec_valid = (count_q != '0);
    dec_pc    = dec_valid ? q_pc_q[rd_ptr_q]    : 32'h0;
    dec_instr = dec_valid ? q_instr_q[rd_ptr_q] : 32'h0;
    dec_comp  = dec_valid ? q_comp_q[rd_ptr_q]  : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SYNC;
      pc_q     <= RESET_PC;
      mode_q   <= M_MODE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc_q[i]    <= 32'h0;
        q_instr_q[i] <= 32'h0;
        q_comp_q[i]  <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          q_pc_q[wr_ptr_q]    <= pc_q;
          q_instr_q[wr_ptr_q] <= push_instr;
          q_comp_q[wr_ptr_q]  <= comp;
          wr_ptr_q            <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = 32'h0;
  logic [1:0]  redirect_mode = 2'b00;
  logic        fence_valid = 1'b0;
  logic        dec_ready = 1'b0;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        dec_comp;
  mem_in_type  fb_in;
  mem_out_type fb_out;

  logic        mr = 1'b0;
  logic [1:0]  prog = 2'd0;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .redirect_mode  (redirect_mode),
    .fence_valid    (fence_valid),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .dec_pc         (dec_pc),
    .dec_instr      (dec_instr),
    .dec_comp       (dec_comp),
    .fetchbuffer_in (fb_in),
    .fetchbuffer_out(fb_out)
  );

  always #5 clk = ~clk;

  // Fetchbuffer stand-in: 32-bit instr {addr[23:0],0x13}; prog 1 patches a mixed stream.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [1:0] p);
    if (p == 2'd1 && a == 32'h0) return 32'h0000_4501;
    if (p == 2'd1 && a == 32'h2) return 32'h00A0_0093;
    if (p == 2'd1 && a == 32'h6) return 32'hFFFF_8082;
    return {a[23:0], 8'h13};
  endfunction

  always_comb begin
    fb_out.mem_ready = mr;
    fb_out.mem_rdata = mem_word(fb_in.mem_addr, prog);
  end

  typedef struct {
    bit          rst;
    bit          rdv;
    logic [31:0] rda;
    logic [1:0]  rdm;
    bit          fv;
    bit          dr;
    bit          mr;
    logic [1:0]  prog;
    bit          ev;
    bit          es;
    bit          ef;
    logic [31:0] ea;
    logic [1:0]  em;
    bit          edv;
    logic [31:0] epc;
    logic [31:0] ein;
    bit          ecp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit r, bit rdv, logic [31:0] rda, logic [1:0] rdm, bit fv,
                              bit dr, bit m, logic [1:0] p, bit ev, bit es, bit ef,
                              logic [31:0] ea, logic [1:0] em, bit edv, logic [31:0] epc,
                              logic [31:0] ein, bit ecp);
    vec_t v;
    v.rst = r; v.rdv = rdv; v.rda = rda; v.rdm = rdm; v.fv = fv; v.dr = dr; v.mr = m;
    v.prog = p; v.ev = ev; v.es = es; v.ef = ef; v.ea = ea; v.em = em; v.edv = edv;
    v.epc = epc; v.ein = ein; v.ecp = ecp;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; redirect_valid = v.rdv; redirect_addr = v.rda; redirect_mode = v.rdm;
    fence_valid = v.fv; dec_ready = v.dr; mr = v.mr; prog = v.prog;
    #1;
    chk("mem_valid", idx, 32'(fb_in.mem_valid), 32'(v.ev));
    chk("mem_spec",  idx, 32'(fb_in.mem_spec),  32'(v.es));
    chk("mem_fence", idx, 32'(fb_in.mem_fence), 32'(v.ef));
    chk("mem_addr",  idx, fb_in.mem_addr, v.ea);
    chk("mem_mode",  idx, 32'(fb_in.mem_mode), 32'(v.em));
    chk("req_fixed", idx, {fb_in.mem_instr, fb_in.mem_wstrb, fb_in.mem_wdata[26:0]},
        32'h8000_0000);
    chk("dec_valid", idx, 32'(dec_valid), 32'(v.edv));
    chk("dec_pc",    idx, dec_pc, v.epc);
    chk("dec_instr", idx, dec_instr, v.ein);
    chk("dec_comp",  idx, 32'(dec_comp), 32'(v.ecp));
  endtask

  initial begin
    // Reset, always-ready 32-bit stream.
    vq.push_back(mk(0,0,0,0,0, 1,1,0, 1,1,0, 32'h0,  3, 0, 32'h0, 32'h0,   0));
    vq.push_back(mk(0,0,0,0,0, 1,1,0, 1,0,0, 32'h4,  3, 1, 32'h0, 32'h13,  0));
    vq.push_back(mk(0,0,0,0,0, 1,1,0, 1,0,0, 32'h8,  3, 1, 32'h4, 32'h413, 0));
    // Miss drains the queue, then decode stalls for 5 cycles.
    vq.push_back(mk(0,0,0,0,0, 1,0,0, 1,0,0, 32'hC,  3, 1, 32'h8, 32'h813, 0));
    vq.push_back(mk(0,0,0,0,0, 0,1,0, 1,0,0, 32'hC,  3, 0, 32'h0, 32'h0,   0));
    vq.push_back(mk(0,0,0,0,0, 0,1,0, 1,0,0, 32'h10, 3, 1, 32'hC, 32'hC13, 0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(0,0,0,0,0, 0,1,0, 0,0,0, 32'h14, 3, 1, 32'hC, 32'hC13, 0));
    vq.push_back(mk(0,0,0,0,0, 1,1,0, 0,0,0, 32'h14, 3, 1, 32'hC,  32'hC13,  0));
    vq.push_back(mk(0,0,0,0,0, 1,1,0, 1,0,0, 32'h14, 3, 1, 32'h10, 32'h1013, 0));
    // Refill to full, then redirect to 0x1235 mode 0 with a same-cycle pop.
    vq.push_back(mk(0,0,0,0,0, 0,1,0, 1,0,0, 32'h18, 3, 1, 32'h14, 32'h1413, 0));
    vq.push_back(mk(0,0,0,0,0, 0,1,0, 0,0,0, 32'h1C, 3, 1, 32'h14, 32'h1413, 0));
    vq.push_back(mk(0,1,32'h1235,0,0, 1,1,0, 0,0,0, 32'h1C, 3, 1, 32'h14, 32'h1413, 0));
    vq.push_back(mk(0,0,0,0,0, 1,1,0, 1,1,0, 32'h1234, 0, 0, 32'h0,    32'h0,        0));
    vq.push_back(mk(0,0,0,0,0, 1,1,0, 1,0,0, 32'h1238, 0, 1, 32'h1234, 32'h0012_3413, 0));
    // fence.i with redirect to 0x100; fence response is discarded, then 16 misses.
    vq.push_back(mk(0,1,32'h100,3,1, 1,1,0, 1,0,0, 32'h123C, 0, 1, 32'h1238, 32'h0012_3813, 0));
    vq.push_back(mk(0,0,0,0,0, 1,1,0, 1,1,1, 32'h100, 3, 0, 32'h0, 32'h0, 0));
    for (int i = 0; i < 16; i++)
      vq.push_back(mk(0,0,0,0,0, 1,0,0, 1,0,0, 32'h100, 3, 0, 32'h0, 32'h0, 0));
    vq.push_back(mk(0,0,0,0,0, 1,1,0, 1,0,0, 32'h100, 3, 0, 32'h0,   32'h0,        0));
    vq.push_back(mk(0,0,0,0,0, 1,1,0, 1,0,0, 32'h104, 3, 1, 32'h100, 32'h0001_0013, 0));
    // Mixed 16/32-bit stream from address 0.
    vq.push_back(mk(0,1,32'h0,3,0, 1,1,1, 1,0,0, 32'h108, 3, 1, 32'h104, 32'h0001_0413, 0));
    vq.push_back(mk(0,0,0,0,0, 1,1,1, 1,1,0, 32'h0, 3, 0, 32'h0, 32'h0,         0));
    vq.push_back(mk(0,0,0,0,0, 1,1,1, 1,0,0, 32'h2, 3, 1, 32'h0, 32'h0000_4501, 1));
    vq.push_back(mk(0,0,0,0,0, 1,1,1, 1,0,0, 32'h6, 3, 1, 32'h2, 32'h00A0_0093, 0));
    // Redirect near the top of the address space to exercise PC wrap.
    vq.push_back(mk(0,1,32'hFFFF_FFFC,3,0, 1,1,1, 1,0,0, 32'h8, 3, 1, 32'h6, 32'h0000_8082, 1));
    vq.push_back(mk(0,0,0,0,0, 1,1,1, 1,1,0, 32'hFFFF_FFFC, 3, 0, 32'h0, 32'h0, 0));

    repeat (2) @(posedge clk);
    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Reset with two queued entries and a stalled request.
    apply(mk(0,0,0,0,0, 0,1,1, 1,0,0, 32'h0, 3, 1, 32'hFFFF_FFFC, 32'hFFFF_FC13, 0), 100);
    apply(mk(0,0,0,0,0, 0,0,1, 0,0,0, 32'h2, 3, 1, 32'hFFFF_FFFC, 32'hFFFF_FC13, 0), 101);
    apply(mk(1,0,0,0,0, 0,0,1, 0,0,0, 32'h2, 3, 1, 32'hFFFF_FFFC, 32'hFFFF_FC13, 0), 102);
    apply(mk(0,0,0,0,0, 0,0,1, 1,1,0, 32'h0, 3, 0, 32'h0, 32'h0, 0), 103);
    apply(mk(0,0,0,0,0, 0,0,1, 1,0,0, 32'h0, 3, 0, 32'h0, 32'h0, 0), 104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
